// File: rtl/alu_pkg.sv
// Shared ALU control encodings: the ALUControl codes, the main-decoder ALUOp
// classes and the Funct/Op constants. Both the control encoder and the EX-stage
// ALU case labels use these, so the two sides cannot drift apart.
package alu_pkg;

   localparam int ALU_CTRL_W = 3;

   typedef logic [ALU_CTRL_W-1:0] alu_ctrl_t;

   // ALUControl codes; 100, 110 and 111 are never produced.
   localparam alu_ctrl_t ALU_ADD = 3'b000;
   localparam alu_ctrl_t ALU_SUB = 3'b001;
   localparam alu_ctrl_t ALU_AND = 3'b010;
   localparam alu_ctrl_t ALU_OR  = 3'b011;
   localparam alu_ctrl_t ALU_SLT = 3'b101;

   // Main-decoder instruction classes.
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_IMM   = 2'b11
   } alu_op_t;

   // R-type funct field values.
   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_SUBU = 6'h23;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;

   // Immediate-class opcodes.
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;

   // True for the codes the ALU implements; lets the consumer flag garbage.
   function automatic logic alu_ctrl_is_legal(input alu_ctrl_t code);
      return (code == ALU_ADD) || (code == ALU_SUB) || (code == ALU_AND) ||
             (code == ALU_OR)  || (code == ALU_SLT);
   endfunction

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// ID-side decode inputs and EX-side registered outputs of the ALU control
// stage. IllegalCount (and its width CNT_W) exist only when
// ALU_CTRL_ILLEGAL_COUNT_EN is defined.
interface alu_ctrl_stage_if #(
   parameter int CTRL_W = 3
`ifdef ALU_CTRL_ILLEGAL_COUNT_EN
   ,
   parameter int CNT_W  = 16
`endif
);

   logic              ValidD;
   logic [1:0]        ALUOpD;
   logic [5:0]        OpD;
   logic [5:0]        FunctD;
   logic              StallE;
   logic              FlushE;
   logic              ClearErr;
   logic [CTRL_W-1:0] ALUControlE;
   logic              ValidE;
   logic              IllegalE;
   logic              ErrSticky;
`ifdef ALU_CTRL_ILLEGAL_COUNT_EN
   logic [CNT_W-1:0]  IllegalCount;
`endif

   // Pipeline/ID side: drives the decode inputs, observes the EX outputs.
   modport master (
      output ValidD, ALUOpD, OpD, FunctD, StallE, FlushE, ClearErr,
      input  ALUControlE, ValidE, IllegalE, ErrSticky
`ifdef ALU_CTRL_ILLEGAL_COUNT_EN
      , input IllegalCount
`endif
   );

   // Control stage side.
   modport slave (
      input  ValidD, ALUOpD, OpD, FunctD, StallE, FlushE, ClearErr,
      output ALUControlE, ValidE, IllegalE, ErrSticky
`ifdef ALU_CTRL_ILLEGAL_COUNT_EN
      , output IllegalCount
`endif
   );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Purely combinational ALU control decode in ID: {ALUOp, Op, Funct} -> ctrl
// plus an illegal-encoding flag. An empty ID slot decodes to ADD and never
// flags, so bubbles carry ALUControl 000.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic      valid,
   input  alu_op_t   alu_op,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output alu_ctrl_t ctrl,
   output logic      illegal
);

   alu_ctrl_t raw_ctrl;
   logic      raw_bad;

   // Class-based decode; unsupported Funct/Op fall back to ADD and flag.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      raw_ctrl = ALU_ADD;
      raw_bad  = 1'b0;
      case (alu_op)
         ALUOP_ADD: raw_ctrl = ALU_ADD;
         ALUOP_SUB: raw_ctrl = ALU_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD, FUNCT_ADDU: raw_ctrl = ALU_ADD;
               FUNCT_SUB, FUNCT_SUBU: raw_ctrl = ALU_SUB;
               FUNCT_AND:             raw_ctrl = ALU_AND;
               FUNCT_OR:              raw_ctrl = ALU_OR;
               FUNCT_SLT:             raw_ctrl = ALU_SLT;
               default:               raw_bad  = 1'b1;
            endcase
         end
         ALUOP_IMM: begin
            case (op)
               OP_ADDI, OP_ADDIU: raw_ctrl = ALU_ADD;
               OP_ANDI:           raw_ctrl = ALU_AND;
               OP_ORI:            raw_ctrl = ALU_OR;
               OP_SLTI:           raw_ctrl = ALU_SLT;
               default:           raw_bad  = 1'b1;
            endcase
         end
         default: raw_ctrl = ALU_ADD;
      endcase
   end

   assign ctrl    = valid ? raw_ctrl : ALU_ADD;
   assign illegal = valid & raw_bad;

endmodule

// File: rtl/alu_ctrl_stage.sv
// ALU control stage: decodes ALUOp/Op/Funct in ID and registers the result into
// the ID/EX boundary with flush-over-stall priority, a sticky illegal-op flag
// and, when ALU_CTRL_ILLEGAL_COUNT_EN is defined, a saturating illegal-op
// counter. All outputs are registered; latency is exactly one cycle.
module alu_ctrl_stage
   import alu_pkg::*;
#(
   parameter int CTRL_W = 3,
   parameter int CNT_W  = 16
) (
   input logic             clk,
   input logic             reset,
   alu_ctrl_stage_if.slave bus
);

   // Elaboration-time guards: the ALU case labels assume the package width.
   if (CTRL_W != ALU_CTRL_W) begin : g_bad_ctrl_w
      $error("alu_ctrl_stage: CTRL_W must equal alu_pkg::ALU_CTRL_W");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("alu_ctrl_stage: CNT_W must be at least 1");
   end

   alu_ctrl_t         dec_ctrl;
   logic              dec_illegal;
   logic              load;
   logic              err_set;
   logic [CTRL_W-1:0] ctrl_q;
   logic              valid_q;
   logic              illegal_q;
   logic              sticky_q;

   alu_ctrl_decode u_decode (
      .valid   (bus.ValidD),
      .alu_op  (alu_op_t'(bus.ALUOpD)),
      .op      (bus.OpD),
      .funct   (bus.FunctD),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal)
   );

   // The register actually accepts the ID slot only when neither flushed nor stalled.
   assign load    = !bus.FlushE && !bus.StallE;
   assign err_set = load && dec_illegal;

   // ID/EX register: flush inserts a bubble, stall holds, otherwise load.
   // NOTE: the async reset clears only these few control flops; there is no storage array to reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q    <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else if (bus.FlushE) begin
         ctrl_q    <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else if (!bus.StallE) begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         ctrl_q    <= CTRL_W'(dec_ctrl);
         valid_q   <= bus.ValidD;
         illegal_q <= dec_illegal;
      end
   end

   // Sticky debug flag: set by an illegal load, cleared by ClearErr; set wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sticky_q <= 1'b0;
      end else if (err_set) begin
         sticky_q <= 1'b1;
      end else if (bus.ClearErr) begin
         sticky_q <= 1'b0;
      end
   end

   assign bus.ALUControlE = ctrl_q;
   assign bus.ValidE      = valid_q;
   assign bus.IllegalE    = illegal_q;
   assign bus.ErrSticky   = sticky_q;

`ifdef ALU_CTRL_ILLEGAL_COUNT_EN
   logic [CNT_W-1:0] count_q;

   // Saturating count of illegal loads; a clear coinciding with a load leaves 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (bus.ClearErr) begin
         count_q <= err_set ? CNT_W'(1) : '0;
      end else if (err_set && (count_q != '1)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign bus.IllegalCount = count_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: each directed vector pushes its
// hand-computed EX-stage response into a queue; a monitor pops and compares
// one cycle later. Counter checks apply when ALU_CTRL_ILLEGAL_COUNT_EN is set.
module tb_alu_ctrl_stage;

   localparam int CNT_W = 2;

   typedef struct {
      string name;
      int    ctrl;
      int    valid;
      int    illegal;
      int    sticky;
      int    count;
   } exp_t;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;
   exp_t sb_q[$];

`ifdef ALU_CTRL_ILLEGAL_COUNT_EN
   alu_ctrl_stage_if #(.CTRL_W(3), .CNT_W(CNT_W)) bus ();
`else
   alu_ctrl_stage_if #(.CTRL_W(3)) bus ();
`endif

   alu_ctrl_stage #(.CTRL_W(3), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one ID-stage vector at the falling edge and queue its expected EX response.
   task automatic issue(input string name, input logic valid, input logic [1:0] aluop,
                        input logic [5:0] op, input logic [5:0] funct, input logic stall,
                        input logic flush, input logic clr, input int e_ctrl, input int e_valid,
                        input int e_ill, input int e_sticky, input int e_cnt);
      exp_t e;
      @(negedge clk);
      bus.ValidD   = valid;
      bus.ALUOpD   = aluop;
      bus.OpD      = op;
      bus.FunctD   = funct;
      bus.StallE   = stall;
      bus.FlushE   = flush;
      bus.ClearErr = clr;
      e.name = name; e.ctrl = e_ctrl; e.valid = e_valid;
      e.illegal = e_ill; e.sticky = e_sticky; e.count = e_cnt;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      int budget;
      budget = 20;
      while (sb_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (sb_q.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"},   32'(bus.ALUControlE), 0);
      check({tag, "_valid"},  32'(bus.ValidE),      0);
      check({tag, "_ill"},    32'(bus.IllegalE),    0);
      check({tag, "_sticky"}, 32'(bus.ErrSticky),   0);
`ifdef ALU_CTRL_ILLEGAL_COUNT_EN
      check({tag, "_count"},  32'(bus.IllegalCount), 0);
`endif
   endtask

   // Monitor: one cycle after each issued vector, compare the registered outputs.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({e.name, "_ctrl"},   32'(bus.ALUControlE), e.ctrl);
         check({e.name, "_valid"},  32'(bus.ValidE),      e.valid);
         check({e.name, "_ill"},    32'(bus.IllegalE),    e.illegal);
         check({e.name, "_sticky"}, 32'(bus.ErrSticky),   e.sticky);
`ifdef ALU_CTRL_ILLEGAL_COUNT_EN
         check({e.name, "_count"},  32'(bus.IllegalCount), e.count);
`endif
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      bus.ValidD   = 1'b0;
      bus.ALUOpD   = 2'b00;
      bus.OpD      = 6'h00;
      bus.FunctD   = 6'h00;
      bus.StallE   = 1'b0;
      bus.FlushE   = 1'b0;
      bus.ClearErr = 1'b0;
      #1 reset = 1'b1;
      #2 check_all_zero("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      //    name        V  ALUOp  Op     Funct  St Fl Cl   ctrl V I S C
      issue("idle",     0, 2'b00, 6'h00, 6'h00, 0, 0, 0,  0, 0, 0, 0, 0);
      issue("r_add",    1, 2'b10, 6'h00, 6'h20, 0, 0, 0,  0, 1, 0, 0, 0);
      issue("r_addu",   1, 2'b10, 6'h00, 6'h21, 0, 0, 0,  0, 1, 0, 0, 0);
      issue("r_sub",    1, 2'b10, 6'h00, 6'h22, 0, 0, 0,  1, 1, 0, 0, 0);
      issue("r_subu",   1, 2'b10, 6'h00, 6'h23, 0, 0, 0,  1, 1, 0, 0, 0);
      issue("r_and",    1, 2'b10, 6'h00, 6'h24, 0, 0, 0,  2, 1, 0, 0, 0);
      issue("r_or",     1, 2'b10, 6'h00, 6'h25, 0, 0, 0,  3, 1, 0, 0, 0);
      issue("r_slt",    1, 2'b10, 6'h00, 6'h2A, 0, 0, 0,  5, 1, 0, 0, 0);
      issue("cls_add",  1, 2'b00, 6'h23, 6'h22, 0, 0, 0,  0, 1, 0, 0, 0);
      issue("cls_sub",  1, 2'b01, 6'h04, 6'h25, 0, 0, 0,  1, 1, 0, 0, 0);
      issue("i_ori",    1, 2'b11, 6'h0D, 6'h00, 0, 0, 0,  3, 1, 0, 0, 0);
      issue("i_slti",   1, 2'b11, 6'h0A, 6'h00, 0, 0, 0,  5, 1, 0, 0, 0);
      issue("r_bad",    1, 2'b10, 6'h00, 6'h27, 0, 0, 0,  0, 1, 1, 1, 1);
      issue("clr1",     0, 2'b00, 6'h00, 6'h00, 0, 0, 1,  0, 0, 0, 0, 0);
      // Stall holds SUB even though a new (illegal) instruction waits in ID.
      issue("ld_sub",   1, 2'b01, 6'h00, 6'h00, 0, 0, 0,  1, 1, 0, 0, 0);
      issue("stall1",   1, 2'b10, 6'h00, 6'h27, 1, 0, 0,  1, 1, 0, 0, 0);
      issue("stall2",   1, 2'b10, 6'h00, 6'h24, 1, 0, 0,  1, 1, 0, 0, 0);
      issue("stall3",   1, 2'b11, 6'h0C, 6'h00, 1, 0, 0,  1, 1, 0, 0, 0);
      issue("st_fl",    1, 2'b11, 6'h0C, 6'h00, 1, 1, 0,  0, 0, 0, 0, 0);
      issue("fl_bad",   1, 2'b10, 6'h00, 6'h27, 0, 1, 0,  0, 0, 0, 0, 0);
      issue("inv_bad",  0, 2'b10, 6'h00, 6'h27, 0, 0, 0,  0, 0, 0, 0, 0);
      issue("inv_sub",  0, 2'b01, 6'h00, 6'h00, 0, 0, 0,  0, 0, 0, 0, 0);
      issue("i_bad",    1, 2'b11, 6'h3F, 6'h00, 0, 0, 0,  0, 1, 1, 1, 1);
      issue("clr2",     0, 2'b00, 6'h00, 6'h00, 0, 0, 1,  0, 0, 0, 0, 0);
      // Counter saturation at CNT_W=2, then clear coinciding with an illegal load.
      issue("bad_c1",   1, 2'b10, 6'h00, 6'h27, 0, 0, 0,  0, 1, 1, 1, 1);
      issue("bad_c2",   1, 2'b10, 6'h00, 6'h3F, 0, 0, 0,  0, 1, 1, 1, 2);
      issue("bad_c3",   1, 2'b11, 6'h01, 6'h00, 0, 0, 0,  0, 1, 1, 1, 3);
      issue("bad_c4",   1, 2'b10, 6'h00, 6'h00, 0, 0, 0,  0, 1, 1, 1, 3);
      issue("bad_c5",   1, 2'b10, 6'h00, 6'h27, 0, 0, 0,  0, 1, 1, 1, 3);
      issue("clr_set",  1, 2'b10, 6'h00, 6'h27, 0, 0, 1,  0, 1, 1, 1, 1);
      issue("clr3",     0, 2'b00, 6'h00, 6'h00, 0, 0, 1,  0, 0, 0, 0, 0);
      issue("ld_or",    1, 2'b10, 6'h00, 6'h25, 0, 0, 0,  3, 1, 0, 0, 0);
      issue("hold_or",  1, 2'b10, 6'h00, 6'h22, 1, 0, 0,  3, 1, 0, 0, 0);
      drain();

      // Asynchronous reset mid-cycle while stalled discards the held instruction.
      @(posedge clk);
      #2 reset = 1'b1;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      reset = 1'b0;
      issue("post_rst", 0, 2'b00, 6'h00, 6'h00, 0, 0, 0,  0, 0, 0, 0, 0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
